// File: rtl/frame_reader.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// frame_reader
// Scanout-side reader for the pixel frame buffer. On each start pulse it walks
// the frame buffer with sequential word-read requests beginning at BASE_WADDR.
// It buffers the in-order read responses in a small FIFO and streams 24-bit
// RGB pixels to the video sink over a valid/ready handshake.
//
// Ports:
//   clk, rst            system clock, synchronous active-high reset
//   start               one-cycle pulse that begins a frame (ignored unless idle)
//   busy, done          frame in progress / one-cycle pulse after the last pixel
//   underrun            sticky: sink was starved while the frame was incomplete
//   req_valid/addr/ready  word-read request channel to the memory arbiter
//   resp_valid/data     in-order read responses (RGB in bits [23:0])
//   pix_valid/data/sof/eof/ready  pixel stream to the display encoder
// -----------------------------------------------------------------------------
module frame_reader #(
   parameter logic [29:0] BASE_WADDR  = 30'h04100000,
   parameter int unsigned FRAME_WORDS = 614000,
   parameter int unsigned FIFO_DEPTH  = 16,
   parameter int unsigned CNT_W       = 20
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   output logic        busy,
   output logic        done,
   output logic        underrun,
   output logic        req_valid,
   output logic [29:0] req_addr,
   input  logic        req_ready,
   input  logic        resp_valid,
   input  logic [31:0] resp_data,
   output logic        pix_valid,
   output logic [23:0] pix_data,
   output logic        pix_sof,
   output logic        pix_eof,
   input  logic        pix_ready
);

   // The pixel counters get one bit beyond CNT_W so that a full 2^20-word
   // frame can still be told apart from "one word short".
   localparam int PTR_W  = $clog2(FIFO_DEPTH);
   localparam int FCNT_W = PTR_W + 1;
   localparam int PC_W   = CNT_W + 1;
   localparam logic [PC_W-1:0]   FRAME_LEN = PC_W'(FRAME_WORDS);
   localparam logic [PC_W-1:0]   LAST_IDX  = PC_W'(FRAME_WORDS - 1);
   localparam logic [FCNT_W:0]   DEPTH_SUM = (FCNT_W + 1)'(FIFO_DEPTH);

   typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

   state_t              state;
   state_t              state_nxt;
   logic [PC_W-1:0]     req_cnt;
   logic [PC_W-1:0]     out_cnt;
   logic [FCNT_W-1:0]   outstanding;
   logic [FCNT_W-1:0]   fifo_count;
   logic [PTR_W-1:0]    wr_ptr;
   logic [PTR_W-1:0]    rd_ptr;
   logic [23:0]         mem [FIFO_DEPTH];
   logic                first_cycle;
   logic                underrun_r;
   logic                done_r;
   logic                start_acc;
   logic                req_hs;
   logic                resp_ok;
   logic                pix_hs;
   logic                last_pix;
   logic [FCNT_W:0]     credit_sum;
   logic                unused_resp_hi;

   // Handshake qualifiers. A response only counts when a request is actually
   // outstanding, so stray responses after a reset never reach the FIFO.
   // Every issued request reserves a FIFO slot through the credit sum, which
   // is what keeps the FIFO from ever overflowing.
   assign start_acc      = (state == IDLE) && start;
   assign req_hs         = req_valid && req_ready;
   assign resp_ok        = resp_valid && (outstanding != '0);
   assign pix_hs         = pix_valid && pix_ready;
   assign last_pix       = pix_hs && (out_cnt == LAST_IDX);
   assign credit_sum     = {1'b0, outstanding} + {1'b0, fifo_count};
   assign unused_resp_hi = ^resp_data[31:24];

   // Output decode. Address and pixel data are forced to zero when their
   // valid is low so the idle bus is quiet.
   assign busy      = (state != IDLE);
   assign done      = done_r;
   assign underrun  = underrun_r;
   assign req_valid = (state == FETCH) && (req_cnt < FRAME_LEN) && (credit_sum < DEPTH_SUM);
   assign req_addr  = req_valid ? (BASE_WADDR + 30'(req_cnt)) : '0;
   assign pix_valid = (fifo_count != '0);
   assign pix_data  = pix_valid ? mem[rd_ptr] : '0;
   assign pix_sof   = pix_valid && (out_cnt == '0);
   assign pix_eof   = pix_valid && (out_cnt == LAST_IDX);

   // Frame sequencing: fetch until every word has been requested, then drain
   // the remaining responses until the sink takes the last pixel.
   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = FETCH;
         FETCH:   if (req_cnt == FRAME_LEN) state_nxt = DRAIN;
         DRAIN:   if (last_pix) state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // State register plus all counters, FIFO pointers and status flags. An
   // accepted start restarts everything for a fresh frame. The underrun check
   // skips the first busy cycle because no data could possibly be there yet.
   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= IDLE;
         req_cnt     <= '0;
         out_cnt     <= '0;
         outstanding <= '0;
         fifo_count  <= '0;
         wr_ptr      <= '0;
         rd_ptr      <= '0;
         first_cycle <= 1'b0;
         underrun_r  <= 1'b0;
         done_r      <= 1'b0;
      end else begin
         state       <= state_nxt;
         done_r      <= (state == DRAIN) && last_pix;
         first_cycle <= start_acc;
         if (start_acc) begin
            req_cnt     <= '0;
            out_cnt     <= '0;
            outstanding <= '0;
            fifo_count  <= '0;
            wr_ptr      <= '0;
            rd_ptr      <= '0;
            underrun_r  <= 1'b0;
         end else begin
            if (req_hs) req_cnt <= req_cnt + 1'b1;
            if (pix_hs) out_cnt <= out_cnt + 1'b1;
            if (resp_ok) wr_ptr <= wr_ptr + 1'b1;
            if (pix_hs) rd_ptr <= rd_ptr + 1'b1;
            case ({req_hs, resp_ok})
               2'b10:   outstanding <= outstanding + 1'b1;
               2'b01:   outstanding <= outstanding - 1'b1;
               default: outstanding <= outstanding;
            endcase
            case ({resp_ok, pix_hs})
               2'b10:   fifo_count <= fifo_count + 1'b1;
               2'b01:   fifo_count <= fifo_count - 1'b1;
               default: fifo_count <= fifo_count;
            endcase
            if (busy && pix_ready && (fifo_count == '0) && (out_cnt < FRAME_LEN) && !first_cycle)
               underrun_r <= 1'b1;
         end
      end
   end

   // Pixel storage. No reset needed: contents are only visible through
   // pix_data while the FIFO count says the entry is live.
   always_ff @(posedge clk) begin
      if (!rst && resp_ok)
         mem[wr_ptr] <= resp_data[23:0];
   end

endmodule

// File: tb/tb_frame_reader.sv
`timescale 1ns/1ps
// -----------------------------------------------------------------------------
// tb_frame_reader
// Directed bench for frame_reader. The main instance runs an 8-word frame with
// a 4-entry FIFO behind a small memory model with programmable latency and
// request back-pressure. A second instance runs a single-word frame driven by
// hand. Outputs are sampled 1ns after each rising edge.
// -----------------------------------------------------------------------------
module tb_frame_reader;

   localparam logic [29:0] BASE = 30'h04100000;
   localparam int          FW   = 8;

   typedef struct {
      logic [29:0] addr;
      int          due;
   } pend_t;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        start = 1'b0;
   logic        req_ready = 1'b1;
   logic        resp_valid = 1'b0;
   logic [31:0] resp_data = '0;
   logic        pix_ready = 1'b0;
   logic        busy, done, underrun, req_valid, pix_valid, pix_sof, pix_eof;
   logic [29:0] req_addr;
   logic [23:0] pix_data;

   logic        s1_start = 1'b0;
   logic        s1_req_ready = 1'b1;
   logic        s1_resp_valid = 1'b0;
   logic [31:0] s1_resp_data = '0;
   logic        s1_pix_ready = 1'b0;
   logic        s1_busy, s1_done, s1_underrun, s1_req_valid, s1_pix_valid, s1_pix_sof, s1_pix_eof;
   logic [29:0] s1_req_addr;
   logic [23:0] s1_pix_data;

   int          vectors = 0;
   int          errors = 0;
   int          cyc = 0;
   int          lat = 2;
   bit          rr_toggle = 1'b0;
   bit          inject = 1'b0;
   pend_t       pend[$];
   logic [29:0] req_log[$];
   logic [23:0] got_d[16];
   logic        got_s[16];
   logic        got_e[16];
   int          got;

   always #5 clk = ~clk;

   frame_reader #(.BASE_WADDR(BASE), .FRAME_WORDS(FW), .FIFO_DEPTH(4), .CNT_W(20)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done), .underrun(underrun),
      .req_valid(req_valid), .req_addr(req_addr), .req_ready(req_ready),
      .resp_valid(resp_valid), .resp_data(resp_data),
      .pix_valid(pix_valid), .pix_data(pix_data), .pix_sof(pix_sof), .pix_eof(pix_eof),
      .pix_ready(pix_ready)
   );

   frame_reader #(.BASE_WADDR(BASE), .FRAME_WORDS(1), .FIFO_DEPTH(4), .CNT_W(20)) dut1 (
      .clk(clk), .rst(rst), .start(s1_start), .busy(s1_busy), .done(s1_done), .underrun(s1_underrun),
      .req_valid(s1_req_valid), .req_addr(s1_req_addr), .req_ready(s1_req_ready),
      .resp_valid(s1_resp_valid), .resp_data(s1_resp_data),
      .pix_valid(s1_pix_valid), .pix_data(s1_pix_data), .pix_sof(s1_pix_sof), .pix_eof(s1_pix_eof),
      .pix_ready(s1_pix_ready)
   );

   // Contents of the frame buffer as seen by the memory model.
   function automatic logic [31:0] mem_word(input logic [29:0] a);
      return {8'hC3, a[23:0] ^ 24'h5A5A5A};
   endfunction

   // Expected RGB for pixel i of a frame starting at BASE.
   function automatic logic [23:0] exp_pix(input int i);
      logic [29:0] a;
      a = BASE + 30'(i);
      return a[23:0] ^ 24'h5A5A5A;
   endfunction

   // Memory model on the falling edge: picks req_ready, answers requests
   // in order after 'lat' cycles, logs accepted addresses, and can inject
   // stray responses. A reset drops everything in flight.
   always @(negedge clk) begin
      pend_t p;
      cyc = cyc + 1;
      req_ready  = rr_toggle ? ((cyc % 3) == 0) : 1'b1;
      resp_valid = 1'b0;
      resp_data  = '0;
      if (rst) begin
         pend.delete();
      end else begin
         if (inject) begin
            resp_valid = 1'b1;
            resp_data  = 32'hDEADBEEF;
         end else if (pend.size() > 0 && pend[0].due <= cyc) begin
            resp_valid = 1'b1;
            resp_data  = mem_word(pend[0].addr);
            void'(pend.pop_front());
         end
         if (req_valid && req_ready) begin
            p.addr = req_addr;
            p.due  = cyc + lat;
            pend.push_back(p);
            req_log.push_back(req_addr);
         end
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic pulse_start();
      start = 1'b1;
      step();
      start = 1'b0;
   endtask

   // Sink for the main instance: records n pixel handshakes. With wait_first
   // set it holds pix_ready low until the first pixel shows up. Returns one
   // cycle after the last handshake.
   task automatic collect(input int n, input bit wait_first, input int max_cyc);
      got = 0;
      for (int c = 0; c < max_cyc && got < n; c++) begin
         if (!wait_first || pix_valid) pix_ready = 1'b1;
         if (pix_valid && pix_ready) begin
            got_d[got] = pix_data;
            got_s[got] = pix_sof;
            got_e[got] = pix_eof;
            got++;
         end
         step();
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) step();
      rst = 1'b0;
      step();
      vectors++;
      if ({busy, done, underrun, req_valid, pix_valid, pix_sof, pix_eof} !== 7'b0) begin
         errors++;
         $display("[TB] FAIL reset_flags: got %b want 0000000", {busy, done, underrun, req_valid, pix_valid, pix_sof, pix_eof});
      end
      vectors++;
      if (req_addr !== 30'h0 || pix_data !== 24'h0) begin
         errors++;
         $display("[TB] FAIL reset_buses: got addr %h data %h want 0 0", req_addr, pix_data);
      end
      vectors++;
      if ({s1_busy, s1_done, s1_underrun, s1_req_valid, s1_pix_valid} !== 5'b0) begin
         errors++;
         $display("[TB] FAIL reset_single: got %b want 00000", {s1_busy, s1_done, s1_underrun, s1_req_valid, s1_pix_valid});
      end
   endtask

   task automatic test_basic_frame();
      lat = 2; rr_toggle = 1'b0; pix_ready = 1'b0;
      req_log.delete();
      pulse_start();
      vectors++;
      if (req_valid !== 1'b1 || req_addr !== BASE) begin
         errors++;
         $display("[TB] FAIL basic_first_req: got v=%b addr %h want v=1 addr %h", req_valid, req_addr, BASE);
      end
      collect(FW, 1'b1, 200);
      vectors++;
      if (got !== FW) begin
         errors++;
         $display("[TB] FAIL basic_count: got %0d want %0d", got, FW);
      end
      for (int i = 0; i < got; i++) begin
         vectors++;
         if (got_d[i] !== exp_pix(i) || got_s[i] !== (i == 0) || got_e[i] !== (i == FW - 1)) begin
            errors++;
            $display("[TB] FAIL basic_pix%0d: got %h sof %b eof %b want %h sof %b eof %b",
                     i, got_d[i], got_s[i], got_e[i], exp_pix(i), (i == 0), (i == FW - 1));
         end
      end
      vectors++;
      if ({done, busy, underrun} !== 3'b100) begin
         errors++;
         $display("[TB] FAIL basic_done: got done/busy/underrun %b want 100", {done, busy, underrun});
      end
      vectors++;
      if (req_log.size() !== FW) begin
         errors++;
         $display("[TB] FAIL basic_req_count: got %0d want %0d", req_log.size(), FW);
      end
      for (int i = 0; i < req_log.size(); i++) begin
         vectors++;
         if (req_log[i] !== BASE + 30'(i)) begin
            errors++;
            $display("[TB] FAIL basic_addr%0d: got %h want %h", i, req_log[i], BASE + 30'(i));
         end
      end
      step();
      vectors++;
      if (done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL basic_done_pulse: got %b want 0", done);
      end
   endtask

   task automatic test_backpressure();
      lat = 2; pix_ready = 1'b0;
      req_log.delete();
      pulse_start();
      repeat (20) step();
      vectors++;
      if (req_log.size() !== 4 || req_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL bp_requests: got %0d req_valid %b want 4 0", req_log.size(), req_valid);
      end
      vectors++;
      if (dut.fifo_count !== 3'd4 || dut.outstanding !== 3'd0) begin
         errors++;
         $display("[TB] FAIL bp_levels: got fifo %0d outst %0d want 4 0", dut.fifo_count, dut.outstanding);
      end
      vectors++;
      if (pix_valid !== 1'b1 || pix_sof !== 1'b1 || pix_data !== exp_pix(0)) begin
         errors++;
         $display("[TB] FAIL bp_head: got v %b sof %b %h want 1 1 %h", pix_valid, pix_sof, pix_data, exp_pix(0));
      end
      collect(FW, 1'b0, 200);
      vectors++;
      if (got !== FW) begin
         errors++;
         $display("[TB] FAIL bp_count: got %0d want %0d", got, FW);
      end
      for (int i = 0; i < got; i++) begin
         vectors++;
         if (got_d[i] !== exp_pix(i) || got_e[i] !== (i == FW - 1)) begin
            errors++;
            $display("[TB] FAIL bp_pix%0d: got %h eof %b want %h eof %b", i, got_d[i], got_e[i], exp_pix(i), (i == FW - 1));
         end
      end
      vectors++;
      if (done !== 1'b1 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL bp_done: got done %b busy %b want 1 0", done, busy);
      end
      step();
   endtask

   task automatic test_req_stall();
      logic        prev_valid;
      logic [29:0] prev_addr;
      int          stalls;
      lat = 2; rr_toggle = 1'b1; pix_ready = 1'b0;
      req_log.delete();
      pulse_start();
      prev_valid = 1'b0; prev_addr = '0; stalls = 0; got = 0;
      for (int c = 0; c < 300 && got < FW; c++) begin
         if (prev_valid && !req_ready) begin
            stalls++;
            vectors++;
            if (req_valid !== 1'b1 || req_addr !== prev_addr) begin
               errors++;
               $display("[TB] FAIL stall_hold: got v %b addr %h want 1 %h", req_valid, req_addr, prev_addr);
            end
         end
         prev_valid = req_valid;
         prev_addr  = req_addr;
         if (pix_valid) pix_ready = 1'b1;
         if (pix_valid && pix_ready) begin
            got_d[got] = pix_data;
            got++;
         end
         step();
      end
      rr_toggle = 1'b0;
      vectors++;
      if (got !== FW || stalls == 0) begin
         errors++;
         $display("[TB] FAIL stall_count: got %0d pixels %0d stalls want %0d pixels >0 stalls", got, stalls, FW);
      end
      for (int i = 0; i < got; i++) begin
         vectors++;
         if (got_d[i] !== exp_pix(i)) begin
            errors++;
            $display("[TB] FAIL stall_pix%0d: got %h want %h", i, got_d[i], exp_pix(i));
         end
      end
      vectors++;
      if (done !== 1'b1) begin
         errors++;
         $display("[TB] FAIL stall_done: got %b want 1", done);
      end
      step();
   endtask

   task automatic test_single_pixel();
      s1_pix_ready = 1'b0;
      s1_start = 1'b1;
      step();
      s1_start = 1'b0;
      vectors++;
      if (s1_req_valid !== 1'b1 || s1_req_addr !== BASE) begin
         errors++;
         $display("[TB] FAIL single_req: got v %b addr %h want 1 %h", s1_req_valid, s1_req_addr, BASE);
      end
      step();
      vectors++;
      if (s1_req_valid !== 1'b0) begin
         errors++;
         $display("[TB] FAIL single_req_once: got %b want 0", s1_req_valid);
      end
      s1_resp_valid = 1'b1;
      s1_resp_data  = 32'hAB123456;
      step();
      s1_resp_valid = 1'b0;
      s1_resp_data  = '0;
      vectors++;
      if ({s1_pix_valid, s1_pix_sof, s1_pix_eof, s1_underrun} !== 4'b1110 || s1_pix_data !== 24'h123456) begin
         errors++;
         $display("[TB] FAIL single_pix: got v/sof/eof/ur %b data %h want 1110 123456",
                  {s1_pix_valid, s1_pix_sof, s1_pix_eof, s1_underrun}, s1_pix_data);
      end
      s1_pix_ready = 1'b1;
      step();
      s1_pix_ready = 1'b0;
      vectors++;
      if ({s1_done, s1_busy, s1_pix_valid} !== 3'b100) begin
         errors++;
         $display("[TB] FAIL single_done: got done/busy/valid %b want 100", {s1_done, s1_busy, s1_pix_valid});
      end
      step();
      vectors++;
      if (s1_done !== 1'b0) begin
         errors++;
         $display("[TB] FAIL single_done_pulse: got %b want 0", s1_done);
      end
   endtask

   task automatic test_reset_midframe();
      lat = 2; pix_ready = 1'b0;
      pulse_start();
      collect(3, 1'b1, 100);
      vectors++;
      if (got !== 3) begin
         errors++;
         $display("[TB] FAIL mid_pre_count: got %0d want 3", got);
      end
      rst = 1'b1;
      step();
      rst = 1'b0;
      vectors++;
      if ({busy, done, underrun, req_valid, pix_valid, pix_sof, pix_eof} !== 7'b0 || req_addr !== 30'h0 || pix_data !== 24'h0) begin
         errors++;
         $display("[TB] FAIL mid_reset_outputs: got %b addr %h data %h want 0000000 0 0",
                  {busy, done, underrun, req_valid, pix_valid, pix_sof, pix_eof}, req_addr, pix_data);
      end
      inject = 1'b1;
      step();
      step();
      inject = 1'b0;
      step();
      vectors++;
      if (pix_valid !== 1'b0 || dut.fifo_count !== 3'd0 || busy !== 1'b0) begin
         errors++;
         $display("[TB] FAIL mid_stray: got valid %b fifo %0d busy %b want 0 0 0", pix_valid, dut.fifo_count, busy);
      end
      req_log.delete();
      pix_ready = 1'b0;
      pulse_start();
      vectors++;
      if (req_valid !== 1'b1 || req_addr !== BASE) begin
         errors++;
         $display("[TB] FAIL mid_restart_addr: got v %b addr %h want 1 %h", req_valid, req_addr, BASE);
      end
      collect(FW, 1'b1, 200);
      vectors++;
      if (got !== FW) begin
         errors++;
         $display("[TB] FAIL mid_count: got %0d want %0d", got, FW);
      end
      for (int i = 0; i < got; i++) begin
         vectors++;
         if (got_d[i] !== exp_pix(i) || got_s[i] !== (i == 0)) begin
            errors++;
            $display("[TB] FAIL mid_pix%0d: got %h sof %b want %h sof %b", i, got_d[i], got_s[i], exp_pix(i), (i == 0));
         end
      end
      vectors++;
      if (done !== 1'b1) begin
         errors++;
         $display("[TB] FAIL mid_done: got %b want 1", done);
      end
      step();
   endtask

   task automatic test_underrun();
      lat = 10; pix_ready = 1'b1;
      req_log.delete();
      pulse_start();
      repeat (4) step();
      vectors++;
      if (underrun !== 1'b1) begin
         errors++;
         $display("[TB] FAIL ur_set: got %b want 1", underrun);
      end
      pulse_start();
      vectors++;
      if (busy !== 1'b1 || underrun !== 1'b1) begin
         errors++;
         $display("[TB] FAIL ur_ignored_start: got busy %b underrun %b want 1 1", busy, underrun);
      end
      collect(FW, 1'b0, 400);
      vectors++;
      if (got !== FW || req_log.size() !== FW) begin
         errors++;
         $display("[TB] FAIL ur_count: got %0d pixels %0d reqs want %0d %0d", got, req_log.size(), FW, FW);
      end
      for (int i = 0; i < got; i++) begin
         vectors++;
         if (got_d[i] !== exp_pix(i)) begin
            errors++;
            $display("[TB] FAIL ur_pix%0d: got %h want %h", i, got_d[i], exp_pix(i));
         end
      end
      vectors++;
      if (done !== 1'b1 || underrun !== 1'b1) begin
         errors++;
         $display("[TB] FAIL ur_done: got done %b underrun %b want 1 1", done, underrun);
      end
      lat = 2; pix_ready = 1'b0;
      step();
      pulse_start();
      vectors++;
      if (underrun !== 1'b0 || busy !== 1'b1) begin
         errors++;
         $display("[TB] FAIL ur_clear: got underrun %b busy %b want 0 1", underrun, busy);
      end
      collect(FW, 1'b1, 200);
      vectors++;
      if (got !== FW || done !== 1'b1 || underrun !== 1'b0) begin
         errors++;
         $display("[TB] FAIL ur_clean_frame: got %0d done %b underrun %b want %0d 1 0", got, done, underrun, FW);
      end
      step();
   endtask

   initial begin
      test_reset();
      test_basic_frame();
      test_backpressure();
      test_req_stall();
      test_single_pixel();
      test_reset_midframe();
      test_underrun();
      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

   initial begin
      #200000;
      $display("[TB] FAIL watchdog: simulation time limit reached");
      $fatal(1, "[TB] watchdog");
   end

endmodule

// File: doc/frame_reader.md
Name: frame_reader

Overview:
- Scanout-side reader for the pixel frame buffer that the CPU program fills by word writes starting at byte address 0x10400000.
- Once per frame, issues sequential word-read requests to the frame-buffer memory port, starting at BASE_WADDR, and buffers the in-order read responses in a small FIFO.
- Streams 24-bit RGB pixels to the video output with a valid/ready handshake.
- Sits between the memory arbiter and the display timing/encoder logic.

Parameters:
BASE_WADDR, 30'h04100000, word address of pixel 0 (byte 0x10400000 >> 2)
FRAME_WORDS, 614000, pixels (words) per frame; legal range 1..2^20
FIFO_DEPTH, 16, pixel buffer entries; power of two, >= 2
CNT_W, 20, width of the pixel counters

Ports:
clk  in  1  system clock
rst  in  1  synchronous, active-high reset
start  in  1  one-cycle pulse: begin a frame
busy  out  1  high from the cycle after an accepted start until the last pixel is accepted
done  out  1  one-cycle pulse in the cycle after the last pixel handshake
underrun  out  1  sticky: sink was ready, FIFO was empty, and the frame was incomplete
req_valid  out  1  read request valid
req_addr  out  30  word address of the request
req_ready  in  1  arbiter accepts the request this cycle
resp_valid  in  1  read data valid; responses arrive in request order, latency >= 1
resp_data  in  32  read data; bits [23:0] hold RGB
pix_valid  out  1  pixel valid
pix_data  out  24  RGB pixel
pix_sof  out  1  qualifies pix_valid; high for pixel 0 only
pix_eof  out  1  qualifies pix_valid; high for pixel FRAME_WORDS-1 only
pix_ready  in  1  sink accepts the pixel

Behaviour:
- Reset: state=IDLE; all counters and FIFO pointers are 0. Outputs busy, done, underrun, req_valid, pix_valid, pix_sof and pix_eof are 0. req_addr and pix_data are 0.
- Reset mid-frame: abandons the frame immediately. Responses still in flight after reset are ignored, because state is IDLE and no request is counted as outstanding.
- States and transitions:
  - IDLE --start--> FETCH. On this transition: req_cnt=0, out_cnt=0, outstanding=0, FIFO flushed, underrun cleared.
  - FETCH --(req_cnt==FRAME_WORDS)--> DRAIN.
  - DRAIN --(last pixel handshake)--> IDLE, with done pulsed one cycle later.
  - start outside IDLE is ignored.
- Requests:
  - req_valid = (state==FETCH) && (req_cnt < FRAME_WORDS) && (outstanding + fifo_count < FIFO_DEPTH). This credit rule makes FIFO overflow impossible.
  - req_addr = BASE_WADDR + req_cnt, 30-bit modulo add.
  - Handshake occurs on req_valid && req_ready. req_valid and req_addr hold stable until accepted.
  - The first request may be asserted in the cycle after start.
- Counters:
  - outstanding increments on a request handshake and decrements on resp_valid. Both in one cycle leaves it unchanged.
  - resp_valid while outstanding==0 is ignored and does not write the FIFO.
- FIFO:
  - Write on counted resp_valid with resp_data[23:0]; read on pix_valid && pix_ready. Simultaneous read and write is allowed, including at full and at empty (write-then-read ordering is not required; count stays consistent).
  - pix_valid = fifo not empty, driven combinationally from the FIFO head register; pix_data = head.
- Pixel framing:
  - pix_sof = pix_valid && out_cnt==0.
  - pix_eof = pix_valid && out_cnt==FRAME_WORDS-1.
  - out_cnt increments on each pixel handshake.
- Status outputs:
  - busy = state != IDLE.
  - underrun sets when busy && pix_ready && fifo empty && out_cnt < FRAME_WORDS, and it is not the cycle immediately after start.
- Throughput: with req_ready=1, fixed response latency L, and pix_ready=1, sustains 1 pixel/clock once FIFO_DEPTH > L+1.
- FRAME_WORDS=1: sof and eof are both high on the single pixel.

Test Plan:
1. FRAME_WORDS=8, FIFO_DEPTH=4, req_ready=1, latency 2, pix_ready=1. Pulse start -> req_addr 0x04100000..0x04100007 in order. 8 pixels equal to resp_data[23:0]. sof on pixel 0, eof on pixel 7. done pulses one cycle after the 8th handshake; busy then 0; underrun 0.
2. Same setup, pix_ready=0 for 20 cycles -> exactly 4 requests issued, fifo_count=4, outstanding=0. Release pix_ready -> remaining 4 pixels follow with no loss or duplication.
3. req_ready toggled 1,0,0,1... -> req_addr holds stable while unaccepted; the full pixel sequence is correct.
4. FRAME_WORDS=1 with resp_data=0xAB123456 -> one pixel 0x123456 with sof=eof=1; then done.
5. Assert rst mid-frame after 3 pixels, then inject 2 stray resp_valid -> outputs return to reset values and the FIFO stays empty. A new start produces a clean frame beginning with sof at address 0x04100000.
6. Response latency 10 with FIFO_DEPTH=4 and pix_ready=1 -> underrun=1 by the first gap. A start pulse while busy is ignored. Next frame's start clears underrun.
